mem_ctrl: RTL
=============

# mem_ctrl

Single-port memory controller between the core's requesters and the byte-wide unified RAM. It arbitrates between instruction fetch (always 4-byte reads) and the load/store buffer (1/2/4-byte reads and writes) and serializes each access into little-endian byte beats. It returns assembled, zero-extended data with a one-cycle done pulse, aborts speculative reads on pipeline clear, and gates stores to the I/O window while the I/O buffer is full.

## Interface
- No parameters.
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- rdy_in  input  1  when low, all state is frozen and no edge has any effect.
- clear  input  1  pipeline flush: aborts in-flight reads.
- io_buffer_full  input  1  I/O output buffer full.
- mem_din  input  8  RAM read data; valid the cycle after its address is presented.
- mem_dout  output  8  RAM write data.
- mem_a  output  32  RAM byte address.
- mem_wr  output  1  1 = write, 0 = read.
- if_req  input  1  fetch request (level); if_addr is held stable until if_done.
- if_addr  input  32  fetch address.
- if_done  output  1  one-cycle pulse; if_data is valid in that cycle.
- if_data  output  32  fetched word {b3,b2,b1,b0}.
- ls_req  input  1  load/store request (level); operands are held stable until ls_done.
- ls_wr  input  1  1 = store.
- ls_size  input  2  00 = byte, 01 = half, 10 = word, 11 = treated as word.
- ls_addr  input  32  start byte address. No alignment is required.
- ls_wdata  input  32  store data; byte i = ls_wdata[8i+7:8i].
- ls_done  output  1  one-cycle pulse.
- ls_rdata  output  32  load data, zero-extended. Sign extension is the requester's job.

## Operation
- States: IDLE, READ, WRITE. A byte counter, the length N (1, 2 or 4), a grant owner (IF/LS) and a last_grant bit are held in registers.
- Grant happens only in IDLE:
  - A requester whose own done is high in the current cycle is ignored.
  - An LS store with ls_addr[17:16]==2'b11 is not eligible while io_buffer_full=1.
  - If exactly one requester is eligible, it is granted.
  - If both are eligible, the requester other than last_grant wins. last_grant resets to IF, so LS wins the first tie.
- READ: byte i is driven as mem_a = start+i (32-bit modulo add). mem_din is captured into byte lane i one cycle later. Lanes at index N and above read as 0.
- WRITE: mem_wr=1, mem_a = start+i, mem_dout = byte i. One byte is written per cycle.
- Completion: state returns to IDLE. The owner's done goes high for exactly one cycle, and its data output is updated in the same edge. if_data and ls_rdata hold their value until the next completion of the same port.
- In IDLE: mem_wr=0, and mem_a/mem_dout hold their last values.
- clear sampled high at an edge:
  - An in-flight READ (IF or LS) returns to IDLE immediately. No done is produced, even if that edge would have completed it.
  - An in-flight WRITE continues to completion and ls_done still pulses, because committed stores must land.
  - No grant occurs at that edge.
- Reset values: mem_a=0, mem_dout=0, mem_wr=0, if_done=0, if_data=0, ls_done=0, ls_rdata=0, state=IDLE, last_grant=IF.
- Reset asserted mid-transaction abandons it at once. No done follows.

## Timing
- The grant edge is E0, at the end of the cycle in which req is sampled.
- Read of N bytes:
  - Cycle i+1 (1≤i+1≤N): mem_a = start+i.
  - Byte i is sampled at edge E(i+2).
  - Done is high in cycle N+2. Fetch: done in cycle 6. Byte load: done in cycle 3.
- Write of N bytes:
  - Cycles 1..N: mem_wr=1, each with its address and data.
  - Done is high in cycle N+1, and mem_wr=0 in that cycle.
- Back-to-back: a new grant may occur at the edge ending a done cycle. That is the other requester, or the same one if it has raised a new req after its done cycle. There are no idle cycles beyond this.
- rdy_in=0 stretches every interval above by the number of frozen cycles. Outputs hold during freeze.

## Test plan
- Fetch: RAM[0x100..0x103] = 13,05,50,00, if_req with if_addr=0x100. Expect if_done in cycle 6 only, if_data=0x00500513, mem_a sequence 0x100..0x103, mem_wr=0 throughout.
- Store then load: ls SW 0xDEADBEEF to 0x200; expect bytes EF,BE,AD,DE written to 0x200..0x203 with ls_done in cycle 5. Then LH from 0x202; expect ls_rdata=0x0000DEAD with ls_done 4 cycles after grant.
- Contention: if_req and ls_req (LB at 0x10) raised in the same cycle after reset. LS is served first, then IF is granted at the edge ending LS's done cycle. Hold both high and check grants alternate.
- Clear: assert clear during cycle 3 of a fetch; expect no if_done and IDLE next cycle. Assert clear during cycle 2 of an SW; expect all 4 bytes written and ls_done in cycle 5.
- I/O gating: io_buffer_full=1 while SB to 0x30000 and if_req are both pending. Expect fetches to proceed and no write to 0x30000. Drop io_buffer_full; expect the store granted next idle cycle with mem_dout=ls_wdata[7:0].
- Reset and freeze: pulse rst_in mid-fetch and check all outputs are 0 asynchronously with no done afterward. Hold rdy_in=0 for 3 cycles mid-read and check done is delayed by exactly 3 cycles with correct data.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates instruction fetch and load/store requests onto a
// byte-wide single-port RAM, serializing each access into little-endian
// byte beats and returning zero-extended data with a one-cycle done pulse.
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_wr,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    state_t      state, state_nxt;
    owner_t      owner, last_grant;
    logic [2:0]  beat;          // READ: index of the address on mem_a; WRITE: byte on the bus
    logic [2:0]  len;           // access length in bytes (1, 2 or 4)
    logic [31:0] start;         // latched start address
    logic [31:0] wdata;         // latched store data
    logic [31:0] rbuf;          // assembled read lanes, unused lanes stay zero

    logic        io_block, if_elig, ls_elig;
    logic        grant_if, grant_ls;
    logic        rd_done, wr_done;
    logic [2:0]  nb, ls_len;
    logic [31:0] next_addr, rd_final;
    logic [7:0]  next_byte;

    // Eligibility and arbitration; grants only from IDLE, never on a clear edge
    always_comb begin
        io_block = ls_wr && (ls_addr[17:16] == 2'b11) && io_buffer_full;
        if_elig  = if_req && !if_done;
        ls_elig  = ls_req && !ls_done && !io_block;
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (state == IDLE && !clear) begin
            if (if_elig && ls_elig) begin
                // tie: the requester that did not win last time goes first
                if (last_grant == OWN_IF) grant_ls = 1'b1;
                else                      grant_if = 1'b1;
            end else if (if_elig) begin
                grant_if = 1'b1;
            end else if (ls_elig) begin
                grant_ls = 1'b1;
            end
        end
    end

    // Beat bookkeeping: next address/byte, completion conditions, final read word
    always_comb begin
        case (ls_size)
            2'b00:   ls_len = 3'd1;
            2'b01:   ls_len = 3'd2;
            default: ls_len = 3'd4;
        endcase
        nb        = beat + 3'd1;
        next_addr = start + {29'd0, nb};
        case (nb)
            3'd1:    next_byte = wdata[15:8];
            3'd2:    next_byte = wdata[23:16];
            default: next_byte = wdata[31:24];
        endcase
        // the last read byte arrives on mem_din in the cycle where beat == len
        rd_done = (state == READ) && !clear && (beat == len);
        wr_done = (state == WRITE) && (beat == len - 3'd1);
        case (len)
            3'd1:    rd_final = rbuf | {24'd0, mem_din};
            3'd2:    rd_final = rbuf | {16'd0, mem_din, 8'd0};
            default: rd_final = rbuf | {mem_din, 24'd0};
        endcase
    end

    // Next-state logic; a clear aborts reads but lets committed writes finish
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_if || (grant_ls && !ls_wr)) state_nxt = READ;
                else if (grant_ls)                    state_nxt = WRITE;
            end
            READ: begin
                if (clear || beat == len) state_nxt = IDLE;
            end
            WRITE: begin
                if (wr_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, frozen while rdy_in is low
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)      state <= IDLE;
        else if (rdy_in) state <= state_nxt;
    end

    // Datapath: latch operands at grant, drive beats, assemble and return data
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem_a      <= 32'd0;
            mem_dout   <= 8'd0;
            mem_wr     <= 1'b0;
            if_done    <= 1'b0;
            if_data    <= 32'd0;
            ls_done    <= 1'b0;
            ls_rdata   <= 32'd0;
            owner      <= OWN_IF;
            last_grant <= OWN_IF;
            beat       <= 3'd0;
            len        <= 3'd0;
            start      <= 32'd0;
            wdata      <= 32'd0;
            rbuf       <= 32'd0;
        end else if (rdy_in) begin
            if_done <= 1'b0;
            ls_done <= 1'b0;
            if (grant_if || grant_ls) begin
                owner      <= grant_if ? OWN_IF : OWN_LS;
                last_grant <= grant_if ? OWN_IF : OWN_LS;
                start      <= grant_if ? if_addr : ls_addr;
                len        <= grant_if ? 3'd4 : ls_len;
                wdata      <= ls_wdata;
                beat       <= 3'd0;
                rbuf       <= 32'd0;
                mem_a      <= grant_if ? if_addr : ls_addr;
                if (grant_ls && ls_wr) begin
                    mem_wr   <= 1'b1;
                    mem_dout <= ls_wdata[7:0];
                end
            end else if (state == READ && !clear) begin
                // mem_din now holds the byte addressed in the previous cycle
                case (beat)
                    3'd1:    rbuf[7:0]   <= mem_din;
                    3'd2:    rbuf[15:8]  <= mem_din;
                    3'd3:    rbuf[23:16] <= mem_din;
                    default: ;
                endcase
                if (nb < len) mem_a <= next_addr;
                beat <= nb;
                if (rd_done) begin
                    if (owner == OWN_IF) begin
                        if_done <= 1'b1;
                        if_data <= rd_final;
                    end else begin
                        ls_done  <= 1'b1;
                        ls_rdata <= rd_final;
                    end
                end
            end else if (state == WRITE) begin
                if (wr_done) begin
                    mem_wr  <= 1'b0;
                    ls_done <= 1'b1;
                end else begin
                    mem_a    <= next_addr;
                    mem_dout <= next_byte;
                    beat     <= nb;
                end
            end
        end
    end

endmodule
